mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL: resetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL: EXE_over  in  1  EXE stage holds a completed instruction.
REQ-004 SHALL: EXE_MEM_bus  in  155  {ls_op[3:0], store_data[31:0], exe_result[31:0], wen, wdest[4:0], data_related_en, lo_result[31:0], hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, pc[31:0]}, MSB first.
REQ-005 SHALL: WB_allow_in  in  1  WB stage can accept.
REQ-006 SHALL: cancel  in  1  flush from WB on syscall/eret.
REQ-007 SHALL: MEM_allow_in  out  1  stage can capture EXE_MEM_bus this cycle.
REQ-008 SHALL: MEM_valid  out  1  stage holds a live instruction.
REQ-009 SHALL: MEM_over  out  1  instruction done; MEM_WB_bus valid.
REQ-010 SHALL: MEM_WB_bus  out  119  {wen, wdest[4:0], data_related_en, mem_result[31:0], lo_result[31:0], hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, pc[31:0]}, MSB first.
REQ-011 SHALL: MEM_wdest  out  5  wdest gated by MEM_valid (0 when invalid), for hazard detection.
REQ-012 SHALL: dm_req / dm_wr  out  1 / 1  data memory request / write select.
REQ-013 SHALL: dm_addr  out  32  word address {exe_result[31:2],2'b00}.
REQ-014 SHALL: dm_wstrb / dm_wdata  out  4 / 32  byte strobes / lane-aligned write data.
REQ-015 SHALL: dm_ack / dm_rdata  in  1 / 32  memory completion / read word (valid with dm_ack).

Function
REQ-016 SHALL: ls_op encoding 0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9-15 treated as none.
REQ-017 SHALL: capture EXE_MEM_bus and set MEM_valid when EXE_over & MEM_allow_in & !cancel; else clear MEM_valid when MEM_over & WB_allow_in.
REQ-018 SHALL: MEM_allow_in = !MEM_valid | (MEM_over & WB_allow_in), forced 0 in DRAIN.
REQ-019 SHALL: FSM states IDLE, REQ, DONE, DRAIN; IDLE->REQ the cycle after capturing a load/store; REQ->DONE on dm_ack; DONE->IDLE (or REQ on back-to-back memory op) when handed to WB.
REQ-020 SHALL: dm_req = 1 exactly in REQ (and DRAIN); address, strobe, data stable until dm_ack.
REQ-021 SHALL: non-memory op: MEM_over = MEM_valid same cycle as capture+1, zero memory cycles.
REQ-022 SHALL: memory op: MEM_over = 1 only in DONE; minimum latency capture->MEM_over 2 cycles with same-cycle ack.
REQ-023 SHALL: stores: SW wstrb 1111, data as-is; SH wstrb 0011/1100 by exe_result[1], data {2{sd[15:0]}}; SB wstrb one-hot by exe_result[1:0], data {4{sd[7:0]}}.
REQ-024 SHALL: loads select byte/half lane by exe_result[1:0]/[1]; LB/LH sign-extend, LBU/LHU zero-extend; read word registered on dm_ack.
REQ-025 SHALL: misaligned low address bits ignored beyond lane selection; no exception raised.
REQ-026 SHALL: mem_result = extended load data for loads, exe_result otherwise; other MEM_WB_bus fields pass through unchanged.
REQ-027 SHALL: cancel in IDLE/DONE clears MEM_valid next edge, no request issued; cancel in REQ moves to DRAIN, keeps dm_req until dm_ack, discards data, then IDLE.
REQ-028 SHALL: cancel and capture same cycle: capture suppressed.

Reset
REQ-029 SHALL: resetn low -> state IDLE, MEM_valid 0, MEM_over 0, dm_req 0, MEM_wdest 0; captured bus register contents unspecified; reset during REQ abandons request without waiting for dm_ack.

Verification
REQ-030 SHALL: ADDU result 0x1234, wdest 5 -> MEM_over 1 cycle after capture, mem_result 0x1234, no dm_req.
REQ-031 SHALL: LB addr 0x103, rdata 0x80FF_FF12, ack after 3 cycles -> dm_addr 0x100, mem_result 0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SHALL: SH addr 0x202, sd 0xABCD -> dm_wr 1, wstrb 1100, wdata 0xABCDABCD.
REQ-033 SHALL: WB_allow_in 0 while DONE -> MEM_over and bus held, MEM_allow_in 0, no new capture.
REQ-034 SHALL: cancel during REQ of LW, ack 2 cycles later -> dm_req held until ack, MEM_valid 0, nothing forwarded, then IDLE.
REQ-035 SHALL: resetn low mid-REQ -> next cycle dm_req 0, MEM_valid 0.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : pipeline memory-access stage (load/store lanes, DM handshake)
// Revision  : 1.0
// ============================================================================
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         EXE_over,
  input  logic [154:0] EXE_MEM_bus,
  input  logic         WB_allow_in,
  input  logic         cancel,
  output logic         MEM_allow_in,
  output logic         MEM_valid,
  output logic         MEM_over,
  output logic [118:0] MEM_WB_bus,
  output logic [4:0]   MEM_wdest,
  output logic         dm_req,
  output logic         dm_wr,
  output logic [31:0]  dm_addr,
  output logic [3:0]   dm_wstrb,
  output logic [31:0]  dm_wdata,
  input  logic         dm_ack,
  input  logic [31:0]  dm_rdata
);

  localparam logic [3:0] LS_LW  = 4'd1;
  localparam logic [3:0] LS_LH  = 4'd2;
  localparam logic [3:0] LS_LHU = 4'd3;
  localparam logic [3:0] LS_LB  = 4'd4;
  localparam logic [3:0] LS_LBU = 4'd5;
  localparam logic [3:0] LS_SW  = 4'd6;
  localparam logic [3:0] LS_SH  = 4'd7;
  localparam logic [3:0] LS_SB  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_valid;
  logic [154:0]   r_bus;
  logic [31:0]    r_rdata;

  logic [3:0]     w_ls_op;
  logic [31:0]    w_sd;
  logic [31:0]    w_er;
  logic [3:0]     w_in_op;
  logic           w_in_mem;
  logic           w_is_mem;
  logic           w_is_load;
  logic           w_is_store;
  logic           w_over;
  logic           w_allow;
  logic           w_cap;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [31:0]    w_load;
  logic [31:0]    w_mem_result;
  logic [3:0]     w_wstrb;
  logic [31:0]    w_wdata;

  assign w_ls_op    = r_bus[154:151];
  assign w_sd       = r_bus[150:119];
  assign w_er       = r_bus[118:87];
  assign w_in_op    = EXE_MEM_bus[154:151];
  assign w_in_mem   = (w_in_op != 4'd0) && (w_in_op <= LS_SB);
  assign w_is_load  = (w_ls_op != 4'd0) && (w_ls_op <= LS_LBU);
  assign w_is_store = (w_ls_op >= LS_SW) && (w_ls_op <= LS_SB);
  assign w_is_mem   = w_is_load | w_is_store;

  assign w_over  = r_valid & ((r_state == S_DONE) | ((r_state == S_IDLE) & ~w_is_mem));
  assign w_allow = (r_state != S_DRAIN) & (~r_valid | (w_over & WB_allow_in));
  assign w_cap   = EXE_over & w_allow & ~cancel;

  // A captured load/store goes straight to REQ so the request is on the bus
  // the cycle after capture.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cap && w_in_mem) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (cancel)      w_state_nxt = dm_ack ? S_IDLE : S_DRAIN;
        else if (dm_ack) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (cancel)                      w_state_nxt = S_IDLE;
        else if (w_over && WB_allow_in)  w_state_nxt = (w_cap && w_in_mem) ? S_REQ : S_IDLE;
      end
      S_DRAIN: begin
        if (dm_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (cancel)                     r_valid <= 1'b0;
      else if (w_cap)                 r_valid <= 1'b1;
      else if (w_over && WB_allow_in) r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap) r_bus <= EXE_MEM_bus;
    if ((r_state == S_REQ) && dm_ack) r_rdata <= dm_rdata;
  end

  always_comb begin
    case (w_er[1:0])
      2'd0:    w_byte = r_rdata[7:0];
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
    w_half = w_er[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (w_ls_op)
      LS_LH:   w_load = {{16{w_half[15]}}, w_half};
      LS_LHU:  w_load = {16'd0, w_half};
      LS_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      LS_LBU:  w_load = {24'd0, w_byte};
      LS_LW:   w_load = r_rdata;
      default: w_load = r_rdata;
    endcase
    w_mem_result = w_is_load ? w_load : w_er;
  end

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = w_sd;
    case (w_ls_op)
      LS_SW: w_wstrb = 4'b1111;
      LS_SH: begin
        w_wstrb = w_er[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{w_sd[15:0]}};
      end
      LS_SB: begin
        w_wstrb = 4'b0001 << w_er[1:0];
        w_wdata = {4{w_sd[7:0]}};
      end
      default: begin
        w_wstrb = 4'b0000;
        w_wdata = w_sd;
      end
    endcase
  end

  assign MEM_allow_in = w_allow;
  assign MEM_valid    = r_valid;
  assign MEM_over     = w_over;
  assign MEM_WB_bus   = {r_bus[86], r_bus[85:81], r_bus[80], w_mem_result, r_bus[79:0]};
  assign MEM_wdest    = r_valid ? r_bus[85:81] : 5'd0;
  assign dm_req       = (r_state == S_REQ) | (r_state == S_DRAIN);
  assign dm_wr        = w_is_store;
  assign dm_addr      = {w_er[31:2], 2'b00};
  assign dm_wstrb     = w_wstrb;
  assign dm_wdata     = w_wdata;

endmodule
`default_nettype wire
